nubus_mem_master: RTL
=====================

NUBUS_MEM_MASTER -- requirements
Module: nubus_mem_master

Interface
REQ-001 Parameter TIMEOUT_CLOCKS, default 255: maximum ACCESS cycles without mem_ready before abort; legal range 1..255.
REQ-002 mem_clk  in  1  single clock; all logic on its rising edge.
REQ-003 mem_reset  in  1  reset is synchronous and active-high.
REQ-004 cmd_valid  in  1  command request from the local agent.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at an edge.
REQ-006 cmd_addr  in  32  byte address.
REQ-007 cmd_wdata  in  32  write data.
REQ-008 cmd_wstrb  in  4  byte strobes; 0 = read, nonzero = write.
REQ-009 mem_valid  out  1  memory access request.
REQ-010 mem_addr  out  32  word address, bits [1:0] always 0.
REQ-011 mem_wdata  out  32  write data.
REQ-012 mem_wstrb  out  4  byte strobes.
REQ-013 mem_rdata  in  32  read data from responder; lanes with strobe set are undriven.
REQ-014 mem_ready  in  1  responder acknowledge; may be combinational from mem_valid.
REQ-015 rsp_valid  out  1  response available.
REQ-016 rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at an edge.
REQ-017 rsp_rdata  out  32  captured read data.
REQ-018 rsp_write  out  1  1 if the completed command was a write.
REQ-019 rsp_error  out  1  1 if the access timed out.
REQ-020 err_count  out  8  saturating count of timed-out accesses.

Function
REQ-021 FSM states IDLE, ACCESS, RESP; exactly one command outstanding.
REQ-022 IDLE: cmd_ready=1, mem_valid=0, rsp_valid=0; on cmd_valid register addr & 32'hFFFFFFFC, wdata, wstrb; next state ACCESS.
REQ-023 ACCESS: mem_valid=1; mem_addr/mem_wdata/mem_wstrb held constant for the whole state; cmd_ready=0.
REQ-024 ACCESS: mem_ready sampled each edge; mem_ready ignored in IDLE and RESP.
REQ-025 ACCESS with mem_ready=1: capture mem_rdata lane-wise -- lane i takes mem_rdata byte i if wstrb[i]=0, else 0; rsp_error=0; next state RESP.
REQ-026 Wait counter cleared on entry to ACCESS, incremented each ACCESS cycle without mem_ready.
REQ-027 Counter reaching TIMEOUT_CLOCKS with mem_ready=0: rsp_rdata=0, rsp_error=1, err_count+1 (saturates at 255); next state RESP; mem_ready on the same edge as timeout wins (normal completion).
REQ-028 RESP: rsp_valid=1, mem_valid=0, cmd_ready=0; rsp_* stable until rsp_ready; on rsp_ready next state IDLE.
REQ-029 rsp_write = (captured wstrb != 0), valid during RESP.
REQ-030 mem_valid SHALL be low for at least two cycles (RESP + IDLE) between consecutive accesses, so responder wait-state pipelines restart.
REQ-031 Minimum latency: cmd accepted edge N; mem_valid high cycle N+1; mem_ready at N+1 gives rsp_valid at N+2; rsp_ready at N+2 gives cmd_ready at N+3.
REQ-032 With responder wait W clocks (mem_ready asserted W cycles after mem_valid), rsp_valid rises W+2 cycles after command accept.
REQ-033 cmd_valid while cmd_ready=0 has no effect; command must be held by the agent.

Reset
REQ-034 mem_reset=1 at an edge: state IDLE, mem_valid=0, mem_addr/mem_wdata/mem_wstrb=0, rsp_valid=0, rsp_rdata=0, rsp_write=0, rsp_error=0, err_count=0, wait counter=0; cmd_ready=1 from the first cycle after reset deasserts.
REQ-035 Reset during ACCESS or RESP abandons the command silently; no response produced.

Verification
REQ-036 Write cmd_addr=0x0000_0013, wdata=0xDEADBEEF, wstrb=4'b1111, responder ready same cycle -> mem_addr=0x10, mem_valid exactly 1 cycle, rsp_valid at N+2, rsp_write=1, rsp_error=0.
REQ-037 Read addr 0x10 after REQ-036, wstrb=0, responder wait 2 clocks -> mem_valid held 3 cycles, rsp_rdata=0xDEADBEEF, rsp_valid at N+4.
REQ-038 Partial write wstrb=4'b0011 -> only lanes 1:0 written; rsp_rdata=0x0000_0000 for strobed lanes; subsequent read returns merged word.
REQ-039 TIMEOUT_CLOCKS=4, mem_ready tied 0 -> rsp_valid after 4 ACCESS cycles, rsp_error=1, rsp_rdata=0, err_count=1; 256 timeouts -> err_count stays 255.
REQ-040 rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready=0, mem_valid=0 throughout; cmd_valid ignored.
REQ-041 mem_reset asserted mid-ACCESS -> next cycle mem_valid=0, rsp_valid=0, cmd_ready=1 after reset release, no response emitted.

Source files
------------

// File: rtl/nubus_mem_master_if.sv
// Bundles the command, memory-access and response channels of nubus_mem_master.
// The master modport is the controller's view; the slave modport is the agent/responder side.
interface nubus_mem_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;

  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_write;
  logic        rsp_error;

  modport master (
    input  cmd_valid, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready,
    output rsp_valid, rsp_rdata, rsp_write, rsp_error,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready,
    input  rsp_valid, rsp_rdata, rsp_write, rsp_error,
    output rsp_ready
  );
endinterface

// File: rtl/nubus_mem_master.sv
// Single-outstanding memory master: accepts one command, runs one word access with
// a wait-state timeout, then holds the response until the agent consumes it.
module nubus_mem_master #(
  parameter int unsigned TIMEOUT_CLOCKS = 255
) (
  input  logic                 mem_clk,
  input  logic                 mem_reset,
  nubus_mem_master_if.master   bus,
  output logic [7:0]           err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [31:0] lane_rdata;
  logic        timeout_hit;

  // Strobed lanes are not driven by the responder, so they read back as zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_rdata[8*gi +: 8] = wstrb_q[gi] ? 8'h00 : bus.mem_rdata[8*gi +: 8];
  end

  assign timeout_hit = (({1'b0, wait_cnt_q} + 9'd1) == 9'(TIMEOUT_CLOCKS));

  always_ff @(posedge mem_clk) begin
    if (mem_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d     = {bus.cmd_addr[31:2], 2'b00};
          wdata_d    = bus.cmd_wdata;
          wstrb_d    = bus.cmd_wstrb;
          wait_cnt_d = '0;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        // A late acknowledge on the timeout edge still counts as a normal completion.
        if (bus.mem_ready) begin
          rdata_d = lane_rdata;
          error_d = 1'b0;
          state_d = RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          error_d = 1'b1;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == IDLE);
    bus.mem_valid = (state_q == ACCESS);
    bus.rsp_valid = (state_q == RESP);
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.mem_wstrb = wstrb_q;
    bus.rsp_rdata = rdata_q;
    bus.rsp_write = (wstrb_q != 4'b0000);
    bus.rsp_error = error_q;
    err_count     = err_cnt_q;
  end

endmodule
